cache_axi_arbiter: RTL and testbench
====================================

// Module: cache_axi_arbiter
// PURPOSE
//  Shares the single cache-side port of the AXI interface among three requesters: ICache refill reads, DCache refill/uncached reads and DCache writebacks.
//  Only one burst is outstanding at a time. Read data and write data/strobe/wlast are wired externally; this block sequences grants, addresses, lengths, valids, beat counting and completion.
// PARAMETERS
//  I_LEN     4'd7  ICache burst length (beats-1)
//  OFF_W     5     line offset bits; a read and a write conflict when addr[31:OFF_W] is equal
//  STARVE_MAX 3'd4  max consecutive write grants while a read is pending
// PORTS
//  clk          in   1   clock
//  rst          in   1   synchronous active-high reset
//  flush_i      in   1   CPU flush; cancel ICache delivery
//  i_req_i      in   1   ICache read request, held until i_done_o
//  i_addr_i     in   32  ICache burst address
//  i_rvalid_o   out  1   ICache read beat valid
//  i_done_o     out  1   ICache burst complete (1-cycle pulse)
//  d_req_i      in   1   DCache read request, held until d_done_o
//  d_addr_i     in   32  DCache read address
//  d_len_i      in   4   DCache read length (beats-1)
//  d_rvalid_o   out  1   DCache read beat valid
//  d_done_o     out  1   DCache read complete (1-cycle pulse)
//  w_req_i      in   1   DCache write request, held until w_done_o
//  w_addr_i     in   32  write address
//  w_len_i      in   4   write length (beats-1)
//  w_valid_i    in   1   write data valid from DCache
//  w_done_o     out  1   write complete (1-cycle pulse)
//  axi_ce_o     out  1   = axi_ren_o | axi_wen_o
//  axi_ren_o    out  1   read transaction active
//  axi_wen_o    out  1   write transaction active
//  axi_raddr_o  out  32  latched read address
//  axi_waddr_o  out  32  latched write address
//  axi_rlen_o   out  4   latched read length
//  axi_wlen_o   out  4   latched write length
//  axi_rready_o out  1   high in RD_I/RD_D
//  axi_wvalid_o out  1   w_valid_i gated by state==WR
//  axi_rvalid_i in   1   read beat returned
//  axi_bvalid_i in   1   write beat accepted (per beat)
// BEHAVIOUR
//  - Reset: state=IDLE; all outputs 0; beat counter 0; round-robin pointer favours I; starve counter 0; drop flag 0.
//  - FSM IDLE->{RD_I,RD_D,WR}->IDLE. Grant is decided in IDLE and registered. Address and length are latched at grant. ren/wen are asserted from the first cycle in the state until the done cycle. There is at least one IDLE cycle between bursts.
//  - IDLE priority:
//    (1) w_req_i and d_req_i with a line conflict -> WR.
//    (2) w_req_i and (no read pending, or starve<STARVE_MAX) -> WR; starve increments if a read was pending.
//    (3) Otherwise reads: if both are pending, grant the one not served last; if one is pending, grant it. A read grant clears starve.
//    i_req_i is ignored in IDLE while flush_i=1.
//  - Read: each axi_rvalid_i&axi_rready_o increments the beat counter and pulses the owner's *_rvalid_o combinationally in the same cycle. When the beat with counter==len arrives, the owner's done pulses in that cycle and the FSM returns to IDLE next cycle.
//  - Write: each axi_bvalid_i counts a beat. When counter==w_len, w_done_o pulses and the FSM returns to IDLE.
//  - flush_i in RD_I (any cycle, including the last beat) sets the drop flag. Remaining beats are consumed with i_rvalid_o and i_done_o suppressed. The flag clears on IDLE.
//  - A requester dropping its req mid-burst is ignored; the burst completes and done still pulses.
//  - A 4-bit counter wraps only via len=15 (16 beats); counter==len is compared exactly.
// TESTING
//  - Only i_req_i, addr 0x1fc00000: axi_raddr_o=0x1fc00000, axi_rlen_o=7; 8 i_rvalid_o pulses; i_done_o pulses on the 8th beat; 1 IDLE cycle follows.
//  - i_req_i and d_req_i together, d_len_i=0, last served = I: D is granted first; after d_done_o, I is granted next.
//  - w_req_i (addr 0x80001000, len 7) and d_req_i (0x80001004): WR runs first; d is granted only after 8 bvalids and w_done_o.
//  - w_req_i held continuously with i_req_i pending, no line conflict: 4 WR grants, then RD_I, then starve counter = 0.
//  - flush_i pulsed at beat 3 of an I burst: 8 beats are consumed with axi_rready_o=1; i_rvalid_o is 0 from beat 3; no i_done_o.
//  - rst asserted mid-RD_D: next cycle all outputs are 0, state=IDLE; a fresh d_req_i is granted normally.

Source files
------------

// File: rtl/cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// cache_axi_arbiter
//
// Purpose:
//   Shares the single cache-side AXI port between three requesters:
//   ICache refill reads, DCache refill/uncached reads and DCache writebacks.
//   Only one burst is in flight at a time.
//
//   This block sequences the following:
//     - grants
//     - latched address and length
//     - read/write enables
//     - beat counting
//     - per-requester completion pulses
//
//   Read data, write data, strobes and wlast are wired outside this block.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush_i                  CPU flush; cancels delivery of an ICache burst
//   i_req_i/i_addr_i         ICache read request and address (fixed length I_LEN)
//   i_rvalid_o/i_done_o      ICache beat valid / burst-complete pulse
//   d_req_i/d_addr_i/d_len_i DCache read request, address, length (beats-1)
//   d_rvalid_o/d_done_o      DCache beat valid / burst-complete pulse
//   w_req_i/w_addr_i/w_len_i DCache writeback request, address, length
//   w_valid_i                write data valid from DCache
//   w_done_o                 writeback complete pulse
//   axi_*_o                  cache-side AXI control (enables, latched addr/len,
//                            rready, gated wvalid)
//   axi_rvalid_i/axi_bvalid_i read beat returned / write beat accepted
// ---------------------------------------------------------------------------
module cache_axi_arbiter #(
  parameter logic [3:0] I_LEN      = 4'd7,
  parameter int         OFF_W      = 5,
  parameter logic [2:0] STARVE_MAX = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  // ICache read port
  input  logic        i_req_i,
  input  logic [31:0] i_addr_i,
  output logic        i_rvalid_o,
  output logic        i_done_o,
  // DCache read port
  input  logic        d_req_i,
  input  logic [31:0] d_addr_i,
  input  logic [3:0]  d_len_i,
  output logic        d_rvalid_o,
  output logic        d_done_o,
  // DCache write port
  input  logic        w_req_i,
  input  logic [31:0] w_addr_i,
  input  logic [3:0]  w_len_i,
  input  logic        w_valid_i,
  output logic        w_done_o,
  // Cache-side AXI control
  output logic        axi_ce_o,
  output logic        axi_ren_o,
  output logic        axi_wen_o,
  output logic [31:0] axi_raddr_o,
  output logic [31:0] axi_waddr_o,
  output logic [3:0]  axi_rlen_o,
  output logic [3:0]  axi_wlen_o,
  output logic        axi_rready_o,
  output logic        axi_wvalid_o,
  input  logic        axi_rvalid_i,
  input  logic        axi_bvalid_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD_I = 2'd1;
  localparam logic [1:0] RD_D = 2'd2;
  localparam logic [1:0] WR   = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  starve_q, starve_d;
  // 1 = ICache was the last read served; reset to 0 so the first tie goes to I.
  logic        last_i_q, last_i_d;
  // Set by a flush during an ICache burst; the rest of the burst is swallowed.
  logic        drop_q, drop_d;
  logic [31:0] raddr_q, raddr_d;
  logic [31:0] waddr_q, waddr_d;
  logic [3:0]  rlen_q, rlen_d;
  logic [3:0]  wlen_q, wlen_d;

  logic i_pend, rd_pend, line_conflict, pick_i;
  logic rd_active, rd_beat, rd_last, wr_last;

  // A flush blocks new ICache grants, so an ICache request under flush is not pending.
  assign i_pend        = i_req_i & ~flush_i;
  assign rd_pend       = i_pend | d_req_i;
  assign line_conflict = w_req_i & d_req_i &
                         (w_addr_i[31:OFF_W] == d_addr_i[31:OFF_W]);
  // On a tie, grant the read that was not served last.
  assign pick_i        = (i_pend & d_req_i) ? ~last_i_q : i_pend;

  assign rd_active = (state_q == RD_I) | (state_q == RD_D);
  assign rd_beat   = rd_active & axi_rvalid_i;
  assign rd_last   = rd_beat & (cnt_q == rlen_q);
  assign wr_last   = (state_q == WR) & axi_bvalid_i & (cnt_q == wlen_q);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    starve_d = starve_q;
    last_i_d = last_i_q;
    drop_d   = drop_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    rlen_d   = rlen_q;
    wlen_d   = wlen_q;

    case (state_q)
      IDLE: begin
        cnt_d  = 4'd0;
        drop_d = 1'b0;
        if (line_conflict ||
            (w_req_i && (!rd_pend || (starve_q < STARVE_MAX)))) begin
          // A write to the same line as the pending DCache read must land
          // first, otherwise the read would return stale data.
          state_d = WR;
          waddr_d = w_addr_i;
          wlen_d  = w_len_i;
          if (rd_pend && (starve_q != 3'd7)) begin
            starve_d = starve_q + 3'd1;
          end
        end else if (rd_pend) begin
          starve_d = 3'd0;
          last_i_d = pick_i;
          if (pick_i) begin
            state_d = RD_I;
            raddr_d = i_addr_i;
            rlen_d  = I_LEN;
          end else begin
            state_d = RD_D;
            raddr_d = d_addr_i;
            rlen_d  = d_len_i;
          end
        end
      end

      RD_I, RD_D: begin
        if ((state_q == RD_I) && flush_i) begin
          drop_d = 1'b1;
        end
        if (rd_last) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (rd_beat) begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      WR: begin
        if (wr_last) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (axi_bvalid_i) begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      starve_q <= 3'd0;
      last_i_q <= 1'b0;
      drop_q   <= 1'b0;
      raddr_q  <= 32'd0;
      waddr_q  <= 32'd0;
      rlen_q   <= 4'd0;
      wlen_q   <= 4'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      last_i_q <= last_i_d;
      drop_q   <= drop_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      rlen_q   <= rlen_d;
      wlen_q   <= wlen_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // ICache delivery is suppressed both by the sticky drop flag and by a
  // flush arriving in the same cycle as a beat (including the last one).
  logic i_deliver;
  assign i_deliver = (state_q == RD_I) & ~drop_q & ~flush_i;

  assign i_rvalid_o = rd_beat & i_deliver;
  assign i_done_o   = rd_last & i_deliver;
  assign d_rvalid_o = rd_beat & (state_q == RD_D);
  assign d_done_o   = rd_last & (state_q == RD_D);
  assign w_done_o   = wr_last;

  assign axi_ren_o    = rd_active;
  assign axi_wen_o    = (state_q == WR);
  assign axi_ce_o     = axi_ren_o | axi_wen_o;
  assign axi_rready_o = rd_active;
  assign axi_wvalid_o = w_valid_i & (state_q == WR);
  assign axi_raddr_o  = raddr_q;
  assign axi_waddr_o  = waddr_q;
  assign axi_rlen_o   = rlen_q;
  assign axi_wlen_o   = wlen_q;

endmodule

// File: tb/tb_cache_axi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cache_axi_arbiter
//
// Directed bench for cache_axi_arbiter with hand-computed expectations.
// Inputs are driven 1 time unit after the rising edge. Outputs are sampled
// 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_cache_axi_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_i;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_rvalid_o, i_done_o;
  logic        d_req_i;
  logic [31:0] d_addr_i;
  logic [3:0]  d_len_i;
  logic        d_rvalid_o, d_done_o;
  logic        w_req_i;
  logic [31:0] w_addr_i;
  logic [3:0]  w_len_i;
  logic        w_valid_i, w_done_o;
  logic        axi_ce_o, axi_ren_o, axi_wen_o;
  logic [31:0] axi_raddr_o, axi_waddr_o;
  logic [3:0]  axi_rlen_o, axi_wlen_o;
  logic        axi_rready_o, axi_wvalid_o;
  logic        axi_rvalid_i, axi_bvalid_i;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  cache_axi_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .i_req_i     (i_req_i),
    .i_addr_i    (i_addr_i),
    .i_rvalid_o  (i_rvalid_o),
    .i_done_o    (i_done_o),
    .d_req_i     (d_req_i),
    .d_addr_i    (d_addr_i),
    .d_len_i     (d_len_i),
    .d_rvalid_o  (d_rvalid_o),
    .d_done_o    (d_done_o),
    .w_req_i     (w_req_i),
    .w_addr_i    (w_addr_i),
    .w_len_i     (w_len_i),
    .w_valid_i   (w_valid_i),
    .w_done_o    (w_done_o),
    .axi_ce_o    (axi_ce_o),
    .axi_ren_o   (axi_ren_o),
    .axi_wen_o   (axi_wen_o),
    .axi_raddr_o (axi_raddr_o),
    .axi_waddr_o (axi_waddr_o),
    .axi_rlen_o  (axi_rlen_o),
    .axi_wlen_o  (axi_wlen_o),
    .axi_rready_o(axi_rready_o),
    .axi_wvalid_o(axi_wvalid_o),
    .axi_rvalid_i(axi_rvalid_i),
    .axi_bvalid_i(axi_bvalid_i)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 unit after the edge (input drive point).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs.
  task automatic settle();
    #1;
  endtask

  // Consume n read beats, checking the per-beat strobe and done of the owner.
  task automatic read_burst(input string tag, input int n, input bit own_i);
    for (int b = 0; b < n; b++) begin
      axi_rvalid_i = 1'b1;
      settle();
      check($sformatf("%s rvalid b%0d", tag, b),
            {31'd0, own_i ? i_rvalid_o : d_rvalid_o}, 32'd1);
      check($sformatf("%s done b%0d", tag, b),
            {31'd0, own_i ? i_done_o : d_done_o}, {31'd0, b == n - 1});
      if (b == n - 1) begin
        if (own_i) i_req_i = 1'b0;
        else       d_req_i = 1'b0;
      end
      tick();
    end
    axi_rvalid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish within the time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    flush_i = 1'b0;
    i_req_i = 1'b0; i_addr_i = 32'd0;
    d_req_i = 1'b0; d_addr_i = 32'd0; d_len_i = 4'd0;
    w_req_i = 1'b0; w_addr_i = 32'd0; w_len_i = 4'd0; w_valid_i = 1'b0;
    axi_rvalid_i = 1'b0; axi_bvalid_i = 1'b0;
    tick(); tick();
    settle();
    // ---- reset state
    check("rst ce",     {31'd0, axi_ce_o}, 32'd0);
    check("rst raddr",  axi_raddr_o, 32'd0);
    check("rst rlen",   {28'd0, axi_rlen_o}, 32'd0);
    check("rst state",  {30'd0, dut.state_q}, 32'd0);
    check("rst starve", {29'd0, dut.starve_q}, 32'd0);
    rst = 1'b0;

    // ---- T1: single ICache burst
    i_req_i = 1'b1; i_addr_i = 32'h1fc0_0000;
    tick(); settle();
    check("t1 ren",   {31'd0, axi_ren_o}, 32'd1);
    check("t1 raddr", axi_raddr_o, 32'h1fc0_0000);
    check("t1 rlen",  {28'd0, axi_rlen_o}, 32'd7);
    read_burst("t1", 8, 1'b1);
    settle();
    check("t1 idle ren",   {31'd0, axi_ren_o}, 32'd0);
    check("t1 idle state", {30'd0, dut.state_q}, 32'd0);

    // ---- T2: I and D together, last served I -> D first, then I
    i_req_i = 1'b1; i_addr_i = 32'h1fc0_0040;
    d_req_i = 1'b1; d_addr_i = 32'h0000_2000; d_len_i = 4'd0;
    tick(); settle();
    check("t2 state rd_d", {30'd0, dut.state_q}, 32'd2);
    check("t2 raddr d",    axi_raddr_o, 32'h0000_2000);
    check("t2 rlen d",     {28'd0, axi_rlen_o}, 32'd0);
    axi_rvalid_i = 1'b1; settle();
    check("t2 i_rvalid quiet", {31'd0, i_rvalid_o}, 32'd0);
    read_burst("t2d", 1, 1'b0);
    settle();
    check("t2 idle gap", {31'd0, axi_ren_o}, 32'd0);
    tick(); settle();
    check("t2 state rd_i", {30'd0, dut.state_q}, 32'd1);
    check("t2 raddr i",    axi_raddr_o, 32'h1fc0_0040);
    read_burst("t2i", 8, 1'b1);

    // ---- T3: write with line conflict runs before the DCache read
    w_req_i = 1'b1; w_addr_i = 32'h8000_1000; w_len_i = 4'd7;
    d_req_i = 1'b1; d_addr_i = 32'h8000_1004; d_len_i = 4'd3;
    tick(); settle();
    check("t3 wen",   {31'd0, axi_wen_o}, 32'd1);
    check("t3 ren",   {31'd0, axi_ren_o}, 32'd0);
    check("t3 waddr", axi_waddr_o, 32'h8000_1000);
    check("t3 wlen",  {28'd0, axi_wlen_o}, 32'd7);
    w_valid_i = 1'b1; settle();
    check("t3 wvalid", {31'd0, axi_wvalid_o}, 32'd1);
    for (int b = 0; b < 8; b++) begin
      axi_bvalid_i = 1'b1; settle();
      check($sformatf("t3 wdone b%0d", b), {31'd0, w_done_o}, {31'd0, b == 7});
      if (b == 7) w_req_i = 1'b0;
      tick();
    end
    axi_bvalid_i = 1'b0; w_valid_i = 1'b0; settle();
    check("t3 idle state", {30'd0, dut.state_q}, 32'd0);
    check("t3 wvalid idle", {31'd0, axi_wvalid_o}, 32'd0);
    tick(); settle();
    check("t3 state rd_d", {30'd0, dut.state_q}, 32'd2);
    check("t3 raddr d",    axi_raddr_o, 32'h8000_1004);
    read_burst("t3d", 4, 1'b0);

    // ---- T4: write starvation limit
    w_req_i = 1'b1; w_addr_i = 32'h8000_0000; w_len_i = 4'd0;
    i_req_i = 1'b1; i_addr_i = 32'h1fc0_0000;
    for (int g = 0; g < 4; g++) begin
      tick(); settle();
      check($sformatf("t4 wr grant %0d", g), {30'd0, dut.state_q}, 32'd3);
      axi_bvalid_i = 1'b1; settle();
      check($sformatf("t4 wdone %0d", g), {31'd0, w_done_o}, 32'd1);
      tick();
      axi_bvalid_i = 1'b0; settle();
    end
    check("t4 starve max", {29'd0, dut.starve_q}, 32'd4);
    tick(); settle();
    check("t4 state rd_i",  {30'd0, dut.state_q}, 32'd1);
    check("t4 starve clr",  {29'd0, dut.starve_q}, 32'd0);
    w_req_i = 1'b0;
    read_burst("t4i", 8, 1'b1);

    // ---- T5: flush at beat 3 of an ICache burst
    i_req_i = 1'b1; i_addr_i = 32'h1fc0_0000;
    tick(); settle();
    check("t5 state rd_i", {30'd0, dut.state_q}, 32'd1);
    for (int b = 0; b < 8; b++) begin
      flush_i = (b == 3);
      axi_rvalid_i = 1'b1; settle();
      check($sformatf("t5 rready b%0d", b), {31'd0, axi_rready_o}, 32'd1);
      check($sformatf("t5 i_rvalid b%0d", b), {31'd0, i_rvalid_o}, {31'd0, b < 3});
      check($sformatf("t5 i_done b%0d", b), {31'd0, i_done_o}, 32'd0);
      if (b == 7) i_req_i = 1'b0;
      tick();
    end
    flush_i = 1'b0; axi_rvalid_i = 1'b0; settle();
    check("t5 idle state", {30'd0, dut.state_q}, 32'd0);

    // ---- T6: reset in the middle of a DCache read
    d_req_i = 1'b1; d_addr_i = 32'h0000_0400; d_len_i = 4'd5;
    tick(); settle();
    check("t6 state rd_d", {30'd0, dut.state_q}, 32'd2);
    axi_rvalid_i = 1'b1; tick(); tick();
    rst = 1'b1;
    tick(); settle();
    check("t6 rst ce",       {31'd0, axi_ce_o}, 32'd0);
    check("t6 rst rready",   {31'd0, axi_rready_o}, 32'd0);
    check("t6 rst d_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    check("t6 rst raddr",    axi_raddr_o, 32'd0);
    check("t6 rst rlen",     {28'd0, axi_rlen_o}, 32'd0);
    check("t6 rst state",    {30'd0, dut.state_q}, 32'd0);
    rst = 1'b0; axi_rvalid_i = 1'b0;
    tick(); settle();
    check("t6 regrant", {30'd0, dut.state_q}, 32'd2);
    check("t6 raddr",   axi_raddr_o, 32'h0000_0400);
    check("t6 rlen",    {28'd0, axi_rlen_o}, 32'd5);
    read_burst("t6d", 6, 1'b0);
    settle();
    check("t6 idle state", {30'd0, dut.state_q}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
